// File: rtl/axi_mem_wr_slave.sv
// AXI4 write-only slave that turns each accepted W beat into a one-cycle memory write strobe.
// One transaction is in flight at a time: address phase, data burst, then a single B response.
module axi_mem_wr_slave #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 16,
   parameter int ID_WIDTH       = 8,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int MEM_SIZE_BYTES = 32768
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [ID_WIDTH-1:0]                       s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]                     s_axi_awaddr,
   input  logic [7:0]                                s_axi_awlen,
   input  logic [2:0]                                s_axi_awsize,
   input  logic [1:0]                                s_axi_awburst,
   input  logic                                      s_axi_awvalid,
   output logic                                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]                     s_axi_wdata,
   input  logic [STRB_WIDTH-1:0]                     s_axi_wstrb,
   input  logic                                      s_axi_wlast,
   input  logic                                      s_axi_wvalid,
   output logic                                      s_axi_wready,
   output logic [ID_WIDTH-1:0]                       s_axi_bid,
   output logic [1:0]                                s_axi_bresp,
   output logic                                      s_axi_bvalid,
   input  logic                                      s_axi_bready,
   output logic                                      mem_wr_en,
   output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0]  mem_wr_addr,
   output logic [DATA_WIDTH-1:0]                     mem_wr_data,
   output logic [STRB_WIDTH-1:0]                     mem_wr_strb,
   output logic                                      busy,
   output logic [15:0]                               err_count
);

   localparam int                  WORD_SHIFT = $clog2(STRB_WIDTH);
   localparam int                  WADDR_W    = ADDR_WIDTH - WORD_SHIFT;
   localparam logic [2:0]          MAX_SIZE   = 3'(WORD_SHIFT);
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT  = (ADDR_WIDTH + 1)'(MEM_SIZE_BYTES);
   localparam logic [1:0]          RESP_OKAY  = 2'b00;
   localparam logic [1:0]          RESP_SLV   = 2'b10;
   localparam logic [1:0]          BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t                  state_r;
   logic [ID_WIDTH-1:0]     id_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [7:0]              len_r;
   logic [2:0]              size_r;
   logic [1:0]              burst_r;
   logic [7:0]              beat_cnt_r;
   logic                    cfg_err_r;
   logic                    err_r;

   logic                    awready_r;
   logic                    wready_r;
   logic                    bvalid_r;
   logic [ID_WIDTH-1:0]     bid_r;
   logic [1:0]              bresp_r;
   logic                    mem_wr_en_r;
   logic [WADDR_W-1:0]      mem_wr_addr_r;
   logic [DATA_WIDTH-1:0]   mem_wr_data_r;
   logic [STRB_WIDTH-1:0]   mem_wr_strb_r;
   logic                    busy_r;
   logic [15:0]             err_count_r;

   logic                    aw_fire_s;
   logic                    beat_fire_s;
   logic                    b_fire_s;
   logic                    beat_last_s;
   logic                    beat_oob_s;
   logic                    beat_err_s;
   logic                    burst_end_s;

   // WRAP, reserved bursts and beats wider than the bus poison the whole burst.
   function automatic logic cfg_bad(input logic [1:0] burst, input logic [2:0] size);
      return (burst[1] == 1'b1) || (size > MAX_SIZE);
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [1:0]            burst,
                                                       input logic [2:0]            size);
      logic [ADDR_WIDTH-1:0] incr_v;
      incr_v = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
      if (burst == BURST_INCR) begin
         return addr + incr_v;
      end else begin
         return addr;
      end
   endfunction

   assign aw_fire_s   = s_axi_awvalid && awready_r;
   assign beat_fire_s = s_axi_wvalid && wready_r;
   assign b_fire_s    = bvalid_r && s_axi_bready;
   assign beat_last_s = (beat_cnt_r == len_r);
   assign beat_oob_s  = ({1'b0, addr_r} >= MEM_LIMIT);
   // A wlast that disagrees with the beat count is an error either way round.
   assign beat_err_s  = beat_oob_s || (s_axi_wlast != beat_last_s);
   assign burst_end_s = beat_last_s || s_axi_wlast;

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         id_r          <= '0;
         addr_r        <= '0;
         len_r         <= 8'd0;
         size_r        <= 3'd0;
         burst_r       <= 2'd0;
         beat_cnt_r    <= 8'd0;
         cfg_err_r     <= 1'b0;
         err_r         <= 1'b0;
         awready_r     <= 1'b0;
         wready_r      <= 1'b0;
         bvalid_r      <= 1'b0;
         bid_r         <= '0;
         bresp_r       <= RESP_OKAY;
         mem_wr_en_r   <= 1'b0;
         mem_wr_addr_r <= '0;
         mem_wr_data_r <= '0;
         mem_wr_strb_r <= '0;
         busy_r        <= 1'b0;
         err_count_r   <= 16'd0;
      end else begin
         mem_wr_en_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (aw_fire_s) begin
                  id_r       <= s_axi_awid;
                  addr_r     <= s_axi_awaddr;
                  len_r      <= s_axi_awlen;
                  size_r     <= s_axi_awsize;
                  burst_r    <= s_axi_awburst;
                  beat_cnt_r <= 8'd0;
                  cfg_err_r  <= cfg_bad(s_axi_awburst, s_axi_awsize);
                  err_r      <= cfg_bad(s_axi_awburst, s_axi_awsize);
                  awready_r  <= 1'b0;
                  wready_r   <= 1'b1;
                  busy_r     <= 1'b1;
                  state_r    <= ST_BURST;
               end else begin
                  awready_r  <= 1'b1;
               end
            end
            ST_BURST: begin
               if (beat_fire_s) begin
                  mem_wr_en_r   <= !cfg_err_r && !beat_oob_s;
                  mem_wr_addr_r <= addr_r[ADDR_WIDTH-1:WORD_SHIFT];
                  mem_wr_data_r <= s_axi_wdata;
                  mem_wr_strb_r <= s_axi_wstrb;
                  addr_r        <= step_addr(addr_r, burst_r, size_r);
                  beat_cnt_r    <= beat_cnt_r + 8'd1;
                  if (burst_end_s) begin
                     wready_r <= 1'b0;
                     bvalid_r <= 1'b1;
                     bid_r    <= id_r;
                     bresp_r  <= (err_r || beat_err_s) ? RESP_SLV : RESP_OKAY;
                     state_r  <= ST_RESP;
                  end else begin
                     err_r    <= err_r || beat_err_s;
                  end
               end
            end
            ST_RESP: begin
               if (b_fire_s) begin
                  bvalid_r  <= 1'b0;
                  awready_r <= 1'b1;
                  busy_r    <= 1'b0;
                  state_r   <= ST_IDLE;
                  if ((bresp_r == RESP_SLV) && (err_count_r != 16'hFFFF)) begin
                     err_count_r <= err_count_r + 16'd1;
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               awready_r <= 1'b0;
               wready_r  <= 1'b0;
               bvalid_r  <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign s_axi_awready = awready_r;
   assign s_axi_wready  = wready_r;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bid     = bid_r;
   assign s_axi_bresp   = bresp_r;
   assign mem_wr_en     = mem_wr_en_r;
   assign mem_wr_addr   = mem_wr_addr_r;
   assign mem_wr_data   = mem_wr_data_r;
   assign mem_wr_strb   = mem_wr_strb_r;
   assign busy          = busy_r;
   assign err_count     = err_count_r;

endmodule

// File: doc/axi_mem_wr_slave.md
AXI_MEM_WR_SLAVE -- requirements
Module: axi_mem_wr_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXI data width in bits (64 or 128).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI byte-address width.
REQ-003 SHALL have parameter ID_WIDTH, default 8, AXI ID width.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, strobe width.
REQ-005 SHALL have parameter MEM_SIZE_BYTES, default 32768, writable span starting at address 0.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 SHALL have ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- s_axi_awid / awaddr / awlen / awsize / awburst  input  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  write address.
- s_axi_awvalid  input  1  address valid.
- s_axi_awready  output  1  address ready.
- s_axi_wdata / wstrb / wlast  input  DATA_WIDTH / STRB_WIDTH / 1  write beat.
- s_axi_wvalid  input  1  beat valid.
- s_axi_wready  output  1  beat ready.
- s_axi_bid / bresp  output  ID_WIDTH / 2  write response.
- s_axi_bvalid  output  1  response valid.
- s_axi_bready  input  1  response ready.
- mem_wr_en  output  1  memory write strobe, one cycle per beat.
- mem_wr_addr  output  ADDR_WIDTH-log2(STRB_WIDTH)  word address.
- mem_wr_data  output  DATA_WIDTH  write data.
- mem_wr_strb  output  STRB_WIDTH  byte enables.
- busy  output  1  high in any state other than IDLE.
- err_count  output  16  saturating count of SLVERR responses issued.

Function
REQ-008 SHALL implement FSM states IDLE, BURST, RESP.
REQ-009 IDLE: awready=1; on awvalid&awready SHALL latch awid, awaddr, awlen, awsize, awburst, clear beat counter and error flag, and go to BURST.
REQ-010 BURST: wready=1, awready=0; each wvalid&wready handshake is one beat.
REQ-011 Each accepted beat SHALL produce, on the next cycle, mem_wr_en=1 with registered word address, wdata, and wstrb; latency exactly 1 cycle; no backpressure from memory.
REQ-012 Address update after each beat: INCR (awburst=1) adds 2^awsize bytes; FIXED (0) holds; widths wrap modulo 2^ADDR_WIDTH.
REQ-013 awburst WRAP (2) or reserved (3), or awsize > log2(STRB_WIDTH), SHALL set error flag; beats are still accepted but mem_wr_en stays 0 for the whole burst.
REQ-014 A beat whose byte address >= MEM_SIZE_BYTES SHALL be suppressed (mem_wr_en=0) and set error flag; other beats in the burst still write.
REQ-015 Burst SHALL end on beat awlen+1 regardless of wlast; wlast=0 on that beat sets error flag; wlast=1 before beat awlen+1 sets error flag and ends the burst immediately.
REQ-016 On burst end SHALL go to RESP: bvalid=1, bid=latched awid, bresp=2'b10 (SLVERR) if error flag else 2'b00 (OKAY); bid/bresp stable while bvalid.
REQ-017 RESP: awready=0, wready=0; on bvalid&bready SHALL go to IDLE with bvalid=0 the next cycle; err_count increments at this handshake if SLVERR, saturating at 0xFFFF.
REQ-018 Only one outstanding transaction; AW presented during BURST/RESP waits, no loss.
REQ-019 W beats arriving before AW SHALL be stalled (wready=0 in IDLE).
REQ-020 Unaligned awaddr SHALL be accepted; first beat uses awaddr word-aligned, wstrb passed unmodified.

Reset
REQ-021 While rst=0 at a clock edge: state=IDLE, awready=0, wready=0, bvalid=0, bid=0, bresp=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_strb=0, busy=0, err_count=0.
REQ-022 awready SHALL rise the first cycle after rst returns to 1; reset mid-burst SHALL abandon the burst with no B response and no further mem_wr_en.

Verification
REQ-023 INCR awaddr=0x0100, awlen=3, awsize=3, 4 beats, wlast on 4th -> mem_wr_en on 4 cycles, word addrs 0x20..0x23, bresp=OKAY, bid=awid.
REQ-024 FIXED awaddr=0x0040, awlen=1 -> two writes both at word 0x08, bresp=OKAY.
REQ-025 INCR awaddr=0x7FF8, awlen=1, MEM_SIZE_BYTES=32768 -> first beat writes word 0xFFF, second suppressed, bresp=SLVERR, err_count=1.
REQ-026 awlen=3 with wlast on beat 2 -> burst ends after 2 writes, bresp=SLVERR; next AW accepted after B handshake.
REQ-027 bready held 0 for 10 cycles -> bvalid, bid, bresp stable, awready=0 throughout; second AW accepted cycle after handshake.
REQ-028 rst=0 asserted after beat 1 of a 4-beat burst -> all outputs at reset values next cycle, no B response, awready=1 first cycle after release.
